fft_bitrev_stream: RTL and testbench

Parametrised AXI4-Stream bit-reversal reorder buffer for the FFT datapath. It sits in the programmable logic between the radix-2 FFT core's natural-order output and the DMA write channel. It accepts frames of N = 2^LOG2N complex samples in natural order and emits each frame in bit-reversed index order, or unchanged when bypass is selected. Ping-pong banking sustains one sample per cycle across back-to-back frames.

---
 rtl/fft_bitrev_stream.sv | 207 ++++++++++++++++++++
 tb/tb_fft_bitrev_stream.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_stream.sv
// fft_bitrev_stream: ping-pong bit-reversal reorder buffer.
// Natural-order frames in, bit-reversed (or bypassed) frames out.
module fft_bitrev_stream #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 10
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic              bypass,
  input  logic              err_clr,
  output logic              frame_err
);

  localparam int N = 1 << LOG2N;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILL,
    B_FULL,
    B_DRAIN
  } bank_t;

  bank_t             r_st [2];
  logic [1:0]        r_byp;
  logic              r_run;
  logic              r_wr_sel;
  logic [LOG2N-1:0]  r_w_cnt;
  logic              r_rd_sel;
  logic [LOG2N-1:0]  r_r_cnt;
  logic              r_err;

  logic [DATA_W-1:0] r_mem [2*N];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_vld;
  logic              r_rd_last;

  logic [1:0]        r_sk_cnt;
  logic [DATA_W-1:0] r_sk_d0;
  logic [DATA_W-1:0] r_sk_d1;
  logic              r_sk_l0;
  logic              r_sk_l1;

  bank_t             w_wr_st;
  bank_t             w_rd_st;
  logic              w_acc;
  logic              w_wlast;
  logic              w_wfirst;
  logic              w_err_set;
  logic              w_rd_avail;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_rlast;
  logic [LOG2N-1:0]  w_rev;
  logic [LOG2N-1:0]  w_raddr;

  assign w_wr_st  = r_st[r_wr_sel];
  assign w_rd_st  = r_st[r_rd_sel];

  assign s_axis_tready = r_run &
    ((w_wr_st == B_EMPTY) | (w_wr_st == B_FILL));

  assign w_acc     = s_axis_tvalid & s_axis_tready;
  assign w_wlast   = (r_w_cnt == {LOG2N{1'b1}});
  assign w_wfirst  = (r_w_cnt == '0);
  assign w_err_set = w_acc & (s_axis_tlast != w_wlast);

  assign w_rd_avail = (w_rd_st == B_FULL) | (w_rd_st == B_DRAIN);
  assign w_pop      = m_axis_tvalid & m_axis_tready;

  // RAM stage plus skid may never hold more than the skid can absorb
  assign w_occ   = {1'b0, r_sk_cnt} + {2'b0, r_rd_vld} - {2'b0, w_pop};
  assign w_issue = w_rd_avail & (w_occ <= 3'd1);
  assign w_rlast = (r_r_cnt == {LOG2N{1'b1}});

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < LOG2N; i++) begin
      w_rev[i] = r_r_cnt[LOG2N-1-i];
    end
  end

  assign w_raddr = r_byp[r_rd_sel] ? r_r_cnt : w_rev;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_st[0]  <= B_EMPTY;
      r_st[1]  <= B_EMPTY;
      r_byp    <= '0;
      r_run    <= 1'b0;
      r_wr_sel <= 1'b0;
      r_w_cnt  <= '0;
      r_rd_sel <= 1'b0;
      r_r_cnt  <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_acc) begin
        r_w_cnt <= r_w_cnt + 1'b1;
        if (w_wfirst) begin
          r_st[r_wr_sel]  <= B_FILL;
          r_byp[r_wr_sel] <= bypass;
        end
        if (w_wlast) begin
          r_st[r_wr_sel] <= B_FULL;
          r_wr_sel       <= ~r_wr_sel;
        end
      end
      if (w_rd_st == B_FULL) begin
        r_st[r_rd_sel] <= B_DRAIN;
      end
      if (w_issue) begin
        r_r_cnt <= r_r_cnt + 1'b1;
        if (w_rlast) begin
          r_st[r_rd_sel] <= B_EMPTY;
          r_rd_sel       <= ~r_rd_sel;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign frame_err = r_err;

  always_ff @(posedge ap_clk) begin
    if (w_acc) begin
      r_mem[{r_wr_sel, r_w_cnt}] <= s_axis_tdata;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[{r_rd_sel, w_raddr}];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_last <= w_rlast;
      end
    end
  end

  // entry 0 is always the head presented on the output
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_sk_cnt <= '0;
      r_sk_d0  <= '0;
      r_sk_d1  <= '0;
      r_sk_l0  <= 1'b0;
      r_sk_l1  <= 1'b0;
    end else begin
      case ({r_rd_vld, w_pop})
        2'b10: begin
          if (r_sk_cnt == 2'd0) begin
            r_sk_d0 <= r_rd_data;
            r_sk_l0 <= r_rd_last;
          end else begin
            r_sk_d1 <= r_rd_data;
            r_sk_l1 <= r_rd_last;
          end
          r_sk_cnt <= r_sk_cnt + 2'd1;
        end
        2'b01: begin
          r_sk_d0  <= r_sk_d1;
          r_sk_l0  <= r_sk_l1;
          r_sk_cnt <= r_sk_cnt - 2'd1;
        end
        2'b11: begin
          if (r_sk_cnt == 2'd1) begin
            r_sk_d0 <= r_rd_data;
            r_sk_l0 <= r_rd_last;
          end else begin
            r_sk_d0 <= r_sk_d1;
            r_sk_l0 <= r_sk_l1;
            r_sk_d1 <= r_rd_data;
            r_sk_l1 <= r_rd_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tvalid = (r_sk_cnt != 2'd0);
  assign m_axis_tdata  = r_sk_d0;
  assign m_axis_tlast  = r_sk_l0 & m_axis_tvalid;

endmodule

// File: tb/tb_fft_bitrev_stream.sv
// tb_fft_bitrev_stream: directed checks of the reorder buffer
// with 8-sample frames, back-pressure, framing errors and reset.
`timescale 1ns/1ps
module tb_fft_bitrev_stream;

  localparam int DW = 32;
  localparam int LG = 3;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          bypass = 1'b0;
  logic          err_clr = 1'b0;
  logic          frame_err;

  fft_bitrev_stream #(.DATA_W(DW), .LOG2N(LG)) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .bypass        (bypass),
    .err_clr       (err_clr),
    .frame_err     (frame_err)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rdy_mode = 0;

  logic [DW-1:0] od [$];
  logic          ol [$];
  int            ot [$];

  logic          pv = 1'b0;
  logic [DW-1:0] pd = '0;
  logic          pl = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  always @(posedge ap_clk) cyc <= cyc + 1;

  always begin
    @(posedge ap_clk);
    #1;
    case (rdy_mode)
      1: m_axis_tready = 1'($urandom_range(0, 1));
      2: m_axis_tready = 1'b0;
      default: m_axis_tready = 1'b1;
    endcase
  end

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv) begin
        chk("stall_vld", 64'(m_axis_tvalid), 64'd1);
        chk("stall_dat", 64'(m_axis_tdata), 64'(pd));
        chk("stall_lst", 64'(m_axis_tlast), 64'(pl));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        od.push_back(m_axis_tdata);
        ol.push_back(m_axis_tlast);
        ot.push_back(cyc);
      end
      pv = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
    end
  end

  task automatic clrq();
    od.delete();
    ol.delete();
    ot.delete();
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d, input logic l,
                     input logic b);
    logic rdy;
    int   n;
    bit   done;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    bypass        = b;
    n    = 0;
    done = 0;
    while (!done) begin
      @(negedge ap_clk);
      rdy = s_axis_tready;
      tick();
      if (rdy) begin
        done = 1;
      end else begin
        n++;
        if (n > 500) begin
          chk("put_tmo", 64'd0, 64'd1);
          done = 1;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // bypass flips after beat 0 so mid-frame changes must be ignored
  task automatic send_frame(input logic [DW-1:0] base, input logic b,
                            input int tl);
    for (int i = 0; i < 8; i++) begin
      put(base + DW'(i), (i == tl), (i == 0) ? b : ~b);
    end
  endtask

  task automatic wait_out(input int cnt);
    int n;
    n = 0;
    while (od.size() < cnt && n < 2000) begin
      tick();
      n++;
    end
    chk("out_cnt", 64'(od.size()), 64'(cnt));
  endtask

  task automatic check_frame(input logic [DW-1:0] base, input logic b);
    int idx;
    for (int i = 0; i < 8; i++) begin
      idx = b ? i : rev3(i);
      if (od.size() == 0) begin
        chk("frm_miss", 64'd0, 64'd1);
        return;
      end
      chk("frm_dat", 64'(od.pop_front()), 64'(base + DW'(idx)));
      chk("frm_lst", 64'(ol.pop_front()), 64'(i == 7));
      void'(ot.pop_front());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp1 [8];
    int kacc;
    exp1 = '{0, 4, 2, 6, 1, 5, 3, 7};

    // reset values
    repeat (3) tick();
    chk("rst_trdy", 64'(s_axis_tready), 64'd0);
    chk("rst_vld", 64'(m_axis_tvalid), 64'd0);
    chk("rst_lst", 64'(m_axis_tlast), 64'd0);
    chk("rst_dat", 64'(m_axis_tdata), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    ap_rst_n = 1'b1;
    tick();
    chk("rel_trdy", 64'(s_axis_tready), 64'd1);

    // natural 0..7 -> bit-reversed, 2-cycle latency
    send_frame(32'd0, 1'b0, 7);
    kacc = cyc;
    wait_out(8);
    if (ot.size() > 0) chk("lat", 64'(ot[0] - kacc), 64'd2);
    for (int i = 0; i < 8 && i < od.size(); i++) begin
      chk("t1_dat", 64'(od[i]), 64'(exp1[i]));
      chk("t1_lst", 64'(ol[i]), 64'(i == 7));
    end
    chk("t1_err", 64'(frame_err), 64'd0);
    clrq();

    // bypass frame then normal frame, back-to-back
    send_frame(32'h100, 1'b1, 7);
    send_frame(32'h200, 1'b0, 7);
    wait_out(16);
    if (ot.size() >= 16) chk("b2b_span", 64'(ot[15] - ot[0]), 64'd15);
    check_frame(32'h100, 1'b1);
    check_frame(32'h200, 1'b0);
    clrq();

    // framing error: tlast on beat 3 instead of 7
    for (int i = 0; i < 8; i++) begin
      put(32'h300 + DW'(i), (i == 3), 1'b0);
      if (i == 2) chk("err_pre", 64'(frame_err), 64'd0);
      if (i == 3) chk("err_set", 64'(frame_err), 64'd1);
    end
    wait_out(8);
    check_frame(32'h300, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 64'(frame_err), 64'd0);
    err_clr = 1'b1;
    put(32'h400, 1'b1, 1'b0);
    err_clr = 1'b0;
    chk("err_win", 64'(frame_err), 64'd1);
    for (int i = 1; i < 8; i++) put(32'h400 + DW'(i), (i == 7), 1'b0);
    chk("err_hold", 64'(frame_err), 64'd1);
    wait_out(8);
    check_frame(32'h400, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr2", 64'(frame_err), 64'd0);
    clrq();

    // input stalls only once both banks are held
    rdy_mode = 2;
    tick();
    send_frame(32'h500, 1'b0, 7);
    send_frame(32'h600, 1'b1, 7);
    @(negedge ap_clk);
    chk("hold_trdy", 64'(s_axis_tready), 64'd0);
    chk("hold_vld", 64'(m_axis_tvalid), 64'd1);
    chk("hold_dat", 64'(m_axis_tdata), 64'h500);
    tick();
    rdy_mode = 0;
    send_frame(32'h700, 1'b0, 7);
    wait_out(24);
    check_frame(32'h500, 1'b0);
    check_frame(32'h600, 1'b1);
    check_frame(32'h700, 1'b0);
    clrq();

    // random back-pressure over several frames
    rdy_mode = 1;
    for (int f = 0; f < 6; f++) begin
      send_frame(DW'(32'h1000 * (f + 1)), f[0], 7);
    end
    wait_out(48);
    rdy_mode = 0;
    for (int f = 0; f < 6; f++) begin
      check_frame(DW'(32'h1000 * (f + 1)), f[0]);
    end
    clrq();

    // reset mid-drain of the second frame
    tick();
    send_frame(32'h2000, 1'b0, 7);
    send_frame(32'h2100, 1'b0, 3);
    wait_out(11);
    chk("pre_rst_err", 64'(frame_err), 64'd1);
    ap_rst_n = 1'b0;
    #1;
    chk("mrst_vld", 64'(m_axis_tvalid), 64'd0);
    chk("mrst_lst", 64'(m_axis_tlast), 64'd0);
    chk("mrst_err", 64'(frame_err), 64'd0);
    chk("mrst_trdy", 64'(s_axis_tready), 64'd0);
    tick();
    ap_rst_n = 1'b1;
    clrq();
    tick();
    chk("mrst_rel", 64'(s_axis_tready), 64'd1);
    chk("mrst_idle", 64'(m_axis_tvalid), 64'd0);
    send_frame(32'd0, 1'b0, 7);
    wait_out(8);
    repeat (10) tick();
    chk("post_cnt", 64'(od.size()), 64'd8);
    for (int i = 0; i < 8 && i < od.size(); i++) begin
      chk("post_dat", 64'(od[i]), 64'(exp1[i]));
      chk("post_lst", 64'(ol[i]), 64'(i == 7));
    end
    chk("post_err", 64'(frame_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
